instr_assembler: RTL and testbench
==================================

INSTR_ASSEMBLER -- requirements
Module: instr_assembler

Interface
REQ-001 Parameter DATA_W, 32, width of one input word.
REQ-002 Parameter WORDS, 2, words per instruction; legal range 1..8.
REQ-003 Parameter DEPTH, 4, instruction FIFO entries; legal range 2..16; need not be a power of two.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 clr  in  1  synchronous clear, active-high.
REQ-007 in_valid  in  1  word present on in_data.
REQ-008 in_ready  out  1  block can accept a word.
REQ-009 in_data  in  DATA_W  instruction word.
REQ-010 in_last  in  1  marks final word of an instruction.
REQ-011 out_valid  out  1  FIFO head instruction present.
REQ-012 out_ready  in  1  consumer accepts head.
REQ-013 out_instr  out  WORDS*DATA_W  head instruction; word 0 in bits [DATA_W-1:0], word k in bits [(k+1)*DATA_W-1:k*DATA_W].
REQ-014 out_count  out  clog2(DEPTH+1)  number of FIFO entries.
REQ-015 err_len  out  1  one-cycle pulse on instruction length error.

Function
REQ-016 A word is accepted on a rising edge with in_valid=1 and in_ready=1; a word is popped on a rising edge with out_valid=1 and out_ready=1.
REQ-017 Assembler states: COLLECT, DROP; a word index widx in 0..WORDS-1 selects the assembly slot.
REQ-018 COLLECT, accepted word, widx<WORDS-1, in_last=0: store word in slot widx, widx+1.
REQ-019 COLLECT, accepted word, widx=WORDS-1, in_last=1: push {word, slots WORDS-2..0} into FIFO on the same edge, widx=0.
REQ-020 COLLECT, accepted word, widx<WORDS-1, in_last=1 (short instruction): discard partial, widx=0, err_len=1 next cycle, no push.
REQ-021 COLLECT, accepted word, widx=WORDS-1, in_last=0 (long instruction): discard, widx=0, enter DROP, err_len=1 next cycle, no push.
REQ-022 DROP: every accepted word discarded; accepted word with in_last=1 returns to COLLECT; no further err_len pulse.
REQ-023 in_ready = 1 in DROP; in COLLECT in_ready = (out_count < DEPTH), evaluated from registered count only (a same-cycle pop does not open in_ready).
REQ-024 Latency: out_valid asserts the cycle after the final word is accepted when the FIFO was empty; out_instr valid in that same cycle.
REQ-025 out_valid = (out_count != 0); out_instr = 0 when FIFO empty.
REQ-026 Simultaneous push and pop: out_count unchanged, both pointers advance.
REQ-027 Read and write pointers wrap from DEPTH-1 to 0.
REQ-028 FIFO order strictly first-in first-out; out_instr stable while out_valid=1 and out_ready=0.
REQ-029 clr=1 overrides all other activity: FIFO emptied, pointers 0, widx 0, state COLLECT, err_len 0; word presented during clr is not accepted as data.
REQ-030 WORDS=1: every word with in_last=1 pushes directly; in_last=0 is a long error (REQ-021).

Reset
REQ-031 reset=0 asynchronously forces: out_valid 0, out_instr 0, out_count 0, err_len 0, in_ready 1, state COLLECT, widx 0, pointers 0, assembly slots 0.
REQ-032 Reset asserted mid-instruction discards the partial instruction and all FIFO contents; first instruction after release starts at slot 0.
REQ-033 No output is undefined after reset.

Verification
REQ-034 WORDS=2: words 0x0004_1234 (last=0), 0x4000_00FF (last=1), out_ready=0 -> next cycle out_valid=1, out_instr=0x4000_00FF_0004_1234, out_count=1.
REQ-035 DEPTH=4, out_ready=0, push 5 complete instructions -> out_count=4, in_ready=0 after 4th; 5th held; raise out_ready -> pops in push order, 5th accepted afterwards.
REQ-036 Short: single word with last=1 -> err_len pulse 1 cycle, out_count stays 0; following valid 2-word instruction delivered intact.
REQ-037 Long: 3 words, last only on 3rd -> err_len 1 pulse, all 3 discarded, out_count 0, next instruction delivered intact.
REQ-038 FIFO at count 2, push and pop same cycle -> count stays 2; cycle 7+ pushes verify pointer wrap with correct order.
REQ-039 Reset and clr each asserted after 1 of 2 words and with 3 queued -> all outputs at REQ-031 values, next instruction assembled from slot 0.

Source files
------------

// File: rtl/instr_assembler.sv
// instr_assembler: collects fixed-length instructions of WORDS input words
// and queues complete instructions in a DEPTH-entry FIFO.
//
// Ports
//   clk, reset    clock (rising edge), asynchronous active-low reset
//   clr           synchronous clear of assembler and FIFO, overrides all
//   in_valid/in_ready/in_data/in_last   word input handshake; in_last marks
//                 the final word of an instruction
//   out_valid/out_ready/out_instr       head-of-FIFO instruction handshake;
//                 word 0 sits in the least significant DATA_W bits
//   out_count     number of queued instructions
//   err_len       one-cycle pulse when an instruction is too short or long
module instr_assembler #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 2,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORDS*DATA_W-1:0]      out_instr,
  output logic [$clog2(DEPTH+1)-1:0]   out_count,
  output logic                         err_len
);

  localparam int INSTR_W = WORDS * DATA_W;
  localparam int IW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = $clog2(DEPTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic {COLLECT, DROP} state_t;

  state_t             state, state_next;
  logic [IW-1:0]      widx, widx_next;
  logic [INSTR_W-1:0] asm_buf;
  logic [INSTR_W-1:0] push_instr;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic               accept, push, pop, err_next, at_last;

  // in_ready looks only at the registered count; a pop in the same cycle
  // does not make room for a word.
  assign in_ready  = (state == DROP) || (out_count < CW'(DEPTH));
  assign accept    = in_valid && in_ready && !clr;
  assign out_valid = (out_count != '0);
  assign pop       = out_valid && out_ready && !clr;
  assign out_instr = out_valid ? mem[rd_ptr] : '0;
  assign at_last   = (widx == LAST_IDX);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_next = state;
    widx_next  = widx;
    push       = 1'b0;
    err_next   = 1'b0;
    // Final word bypasses the slot buffer so the push happens on its edge.
    push_instr = asm_buf;
    push_instr[(WORDS-1)*DATA_W +: DATA_W] = in_data;
    if (clr) begin
      state_next = COLLECT;
      widx_next  = '0;
    end else if (accept) begin
      case (state)
        COLLECT: begin
          if (at_last) begin
            widx_next = '0;
            if (in_last) begin
              push = 1'b1;
            end else begin
              err_next   = 1'b1;
              state_next = DROP;
            end
          end else if (in_last) begin
            widx_next = '0;
            err_next  = 1'b1;
          end else begin
            widx_next = widx + 1'b1;
          end
        end
        DROP: begin
          if (in_last) state_next = COLLECT;
        end
        default: state_next = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= COLLECT;
      widx    <= '0;
      err_len <= 1'b0;
      asm_buf <= '0;
    end else begin
      state   <= state_next;
      widx    <= widx_next;
      err_len <= err_next;
      if (accept && state == COLLECT)
        asm_buf[int'(widx)*DATA_W +: DATA_W] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_count <= '0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   out_count <= out_count + 1'b1;
        2'b01:   out_count <= out_count - 1'b1;
        default: out_count <= out_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_instr;
  end

endmodule

// File: tb/tb_instr_assembler.sv
module tb_instr_assembler;
  localparam int DATA_W = 32;
  localparam int WORDS  = 2;
  localparam int DEPTH  = 4;
  localparam int IW     = WORDS * DATA_W;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk, reset, clr, in_valid, in_ready, in_last;
  logic              out_valid, out_ready, err_len;
  logic [DATA_W-1:0] in_data;
  logic [IW-1:0]     out_instr;
  logic [CW-1:0]     out_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of complete instructions, list of words
  // gathered so far for the current instruction, and a drop flag.
  logic [IW-1:0]     m_fifo[$];
  logic [DATA_W-1:0] m_part[$];
  bit                m_drop;
  bit                m_err;

  instr_assembler #(.DATA_W(DATA_W), .WORDS(WORDS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_count(out_count), .err_len(err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [DATA_W-1:0] make_word(input int i, input int k);
    return 32'hA000_0000 + DATA_W'(i * 256 + k);
  endfunction

  function automatic logic [IW-1:0] make_instr(input int i);
    logic [IW-1:0] r;
    r = '0;
    for (int k = 0; k < WORDS; k++) r[k*DATA_W +: DATA_W] = make_word(i, k);
    return r;
  endfunction

  function automatic logic [IW-1:0] exp_head();
    return (m_fifo.size() != 0) ? m_fifo[0] : '0;
  endfunction

  task automatic model_clear();
    m_fifo.delete();
    m_part.delete();
    m_drop = 0;
    m_err  = 0;
  endtask

  task automatic model_step(input bit v, input logic [DATA_W-1:0] d, input bit l,
                            input bit ordy, input bit c);
    bit rdy, do_pop, do_push, err;
    logic [IW-1:0] ins;
    if (c) begin
      model_clear();
      return;
    end
    rdy     = m_drop || (m_fifo.size() < DEPTH);
    do_pop  = ordy && (m_fifo.size() != 0);
    do_push = 0;
    err     = 0;
    ins     = '0;
    if (v && rdy) begin
      if (m_drop) begin
        if (l) m_drop = 0;
      end else begin
        m_part.push_back(d);
        if (l) begin
          if (m_part.size() == WORDS) begin
            for (int k = 0; k < WORDS; k++) ins[k*DATA_W +: DATA_W] = m_part[k];
            do_push = 1;
          end else begin
            err = 1;
          end
          m_part.delete();
        end else if (m_part.size() == WORDS) begin
          err    = 1;
          m_drop = 1;
          m_part.delete();
        end
      end
    end
    if (do_pop) void'(m_fifo.pop_front());
    if (do_push) m_fifo.push_back(ins);
    m_err = err;
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit l,
                       input bit ordy, input bit c);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    clr       = c;
    model_step(v, d, l, ordy, c);
    @(posedge clk);
    #1;
  endtask

  task automatic send_instr(input int i, input bit ordy);
    for (int k = 0; k < WORDS; k++) drive(1, make_word(i, k), k == WORDS - 1, ordy, 0);
  endtask

  task automatic drain();
    for (int n = 0; n < 4 * DEPTH && m_fifo.size() != 0; n++) drive(0, '0, 0, 1, 0);
    drive(0, '0, 0, 0, 0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec += 5;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    if (out_instr !== '0) begin n_err++; $display("FAIL reset_out_instr: got %h, expected 0", out_instr); end
    if (out_count !== '0) begin n_err++; $display("FAIL reset_out_count: got %0d, expected 0", out_count); end
    if (err_len !== 1'b0) begin n_err++; $display("FAIL reset_err_len: got %b, expected 0", err_len); end
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    reset = 1'b1;
    model_clear();
    drive(0, '0, 0, 0, 0);
  endtask

  task automatic test_basic();
    drive(1, 32'h0004_1234, 0, 0, 0);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b, expected 0", out_valid); end
    drive(1, 32'h4000_00FF, 1, 0, 0);
    n_vec += 3;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b, expected 1", out_valid); end
    if (out_instr !== 64'h4000_00FF_0004_1234) begin n_err++; $display("FAIL basic_instr: got %h, expected 4000_00ff_0004_1234", out_instr); end
    if (out_count !== CW'(1)) begin n_err++; $display("FAIL basic_count: got %0d, expected 1", out_count); end
    drain();
    n_vec++;
    if (out_count !== '0) begin n_err++; $display("FAIL basic_drain: got %0d, expected 0", out_count); end
  endtask

  task automatic test_full();
    int pidx, wi;
    bit v, acc;
    for (int i = 0; i < DEPTH; i++) send_instr(i, 0);
    n_vec += 2;
    if (out_count !== CW'(DEPTH)) begin n_err++; $display("FAIL full_count: got %0d, expected %0d", out_count, DEPTH); end
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b, expected 0", in_ready); end
    drive(1, make_word(DEPTH, 0), 0, 0, 0);
    drive(1, make_word(DEPTH, 0), 0, 0, 0);
    n_vec += 2;
    if (out_count !== CW'(DEPTH)) begin n_err++; $display("FAIL full_held_count: got %0d, expected %0d", out_count, DEPTH); end
    if (out_instr !== make_instr(0)) begin n_err++; $display("FAIL full_held_head: got %h, expected %h", out_instr, make_instr(0)); end
    pidx = 0;
    wi   = 0;
    for (int cyc = 0; cyc < 40 && pidx <= DEPTH; cyc++) begin
      if (out_valid) begin
        n_vec++;
        if (out_instr !== make_instr(pidx)) begin
          n_err++;
          $display("FAIL full_pop_order[%0d]: got %h, expected %h", pidx, out_instr, make_instr(pidx));
        end
        pidx++;
      end
      v   = (wi < WORDS);
      acc = v && in_ready;
      drive(v, make_word(DEPTH, wi), wi == WORDS - 1, 1, 0);
      if (acc) wi++;
    end
    n_vec++;
    if (pidx != DEPTH + 1) begin n_err++; $display("FAIL full_pop_total: got %0d, expected %0d", pidx, DEPTH + 1); end
    drain();
  endtask

  task automatic test_short();
    drive(1, 32'h1111_1111, 1, 0, 0);
    n_vec += 2;
    if (err_len !== 1'b1) begin n_err++; $display("FAIL short_err: got %b, expected 1", err_len); end
    if (out_count !== '0) begin n_err++; $display("FAIL short_count: got %0d, expected 0", out_count); end
    drive(0, '0, 0, 0, 0);
    n_vec++;
    if (err_len !== 1'b0) begin n_err++; $display("FAIL short_err_pulse: got %b, expected 0", err_len); end
    send_instr(7, 0);
    n_vec++;
    if (out_instr !== make_instr(7)) begin n_err++; $display("FAIL short_next: got %h, expected %h", out_instr, make_instr(7)); end
    drain();
  endtask

  task automatic test_long();
    drive(1, 32'h2222_0000, 0, 0, 0);
    n_vec++;
    if (err_len !== 1'b0) begin n_err++; $display("FAIL long_err_early: got %b, expected 0", err_len); end
    drive(1, 32'h2222_0001, 0, 0, 0);
    n_vec += 2;
    if (err_len !== 1'b1) begin n_err++; $display("FAIL long_err: got %b, expected 1", err_len); end
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL long_drop_ready: got %b, expected 1", in_ready); end
    drive(1, 32'h2222_0002, 1, 0, 0);
    n_vec += 2;
    if (err_len !== 1'b0) begin n_err++; $display("FAIL long_err_pulse: got %b, expected 0", err_len); end
    if (out_count !== '0) begin n_err++; $display("FAIL long_count: got %0d, expected 0", out_count); end
    send_instr(8, 0);
    n_vec += 2;
    if (out_instr !== make_instr(8)) begin n_err++; $display("FAIL long_next: got %h, expected %h", out_instr, make_instr(8)); end
    if (out_count !== CW'(1)) begin n_err++; $display("FAIL long_next_count: got %0d, expected 1", out_count); end
    drain();
  endtask

  task automatic test_simul_wrap();
    send_instr(10, 0);
    send_instr(11, 0);
    drive(1, make_word(12, 0), 0, 0, 0);
    drive(1, make_word(12, 1), 1, 1, 0);
    n_vec += 2;
    if (out_count !== CW'(2)) begin n_err++; $display("FAIL simul_count: got %0d, expected 2", out_count); end
    if (out_instr !== make_instr(11)) begin n_err++; $display("FAIL simul_head: got %h, expected %h", out_instr, make_instr(11)); end
    for (int i = 13; i < 21; i++) begin
      send_instr(i, 1);
      n_vec += 2;
      if (out_count !== CW'(m_fifo.size())) begin n_err++; $display("FAIL wrap_count: got %0d, expected %0d", out_count, m_fifo.size()); end
      if (out_instr !== exp_head()) begin n_err++; $display("FAIL wrap_head: got %h, expected %h", out_instr, exp_head()); end
    end
    for (int n = 0; n < 4 * DEPTH && m_fifo.size() != 0; n++) begin
      n_vec++;
      if (out_instr !== exp_head()) begin n_err++; $display("FAIL wrap_drain: got %h, expected %h", out_instr, exp_head()); end
      drive(0, '0, 0, 1, 0);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_empty: got %b, expected 0", out_valid); end
  endtask

  task automatic test_abort(input bit use_reset);
    for (int i = 0; i < 3; i++) send_instr(40 + i, 0);
    drive(1, make_word(30, 0), 0, 0, 0);
    if (use_reset) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      #2 reset = 1'b0;
      model_clear();
      #1;
    end else begin
      drive(1, 32'hDEAD_BEEF, 1, 1, 1);
    end
    n_vec += 5;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort%0d_valid: got %b, expected 0", use_reset, out_valid); end
    if (out_instr !== '0) begin n_err++; $display("FAIL abort%0d_instr: got %h, expected 0", use_reset, out_instr); end
    if (out_count !== '0) begin n_err++; $display("FAIL abort%0d_count: got %0d, expected 0", use_reset, out_count); end
    if (err_len !== 1'b0) begin n_err++; $display("FAIL abort%0d_err: got %b, expected 0", use_reset, err_len); end
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort%0d_ready: got %b, expected 1", use_reset, in_ready); end
    if (use_reset) begin
      in_valid = 1'b0;
      reset    = 1'b1;
      drive(0, '0, 0, 0, 0);
    end
    send_instr(31, 0);
    n_vec += 2;
    if (out_instr !== make_instr(31)) begin n_err++; $display("FAIL abort%0d_next: got %h, expected %h", use_reset, out_instr, make_instr(31)); end
    if (out_count !== CW'(1)) begin n_err++; $display("FAIL abort%0d_next_count: got %0d, expected 1", use_reset, out_count); end
    drain();
  endtask

  task automatic test_random();
    bit v, l, o, c;
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 1) == 1);
      c = ($urandom_range(0, 59) == 0);
      if (m_drop) l = ($urandom_range(0, 1) == 1);
      else if (m_part.size() == WORDS - 1) l = ($urandom_range(0, 9) != 0);
      else l = ($urandom_range(0, 9) == 0);
      drive(v, DATA_W'($urandom), l, o, c);
      n_vec += 5;
      if (out_valid !== (m_fifo.size() != 0)) begin n_err++; $display("FAIL rand_valid @%0d: got %b, expected %b", n, out_valid, m_fifo.size() != 0); end
      if (out_count !== CW'(m_fifo.size())) begin n_err++; $display("FAIL rand_count @%0d: got %0d, expected %0d", n, out_count, m_fifo.size()); end
      if (out_instr !== exp_head()) begin n_err++; $display("FAIL rand_instr @%0d: got %h, expected %h", n, out_instr, exp_head()); end
      if (in_ready !== (m_drop || m_fifo.size() < DEPTH)) begin n_err++; $display("FAIL rand_ready @%0d: got %b, expected %b", n, in_ready, m_drop || m_fifo.size() < DEPTH); end
      if (err_len !== m_err) begin n_err++; $display("FAIL rand_err @%0d: got %b, expected %b", n, err_len, m_err); end
    end
  endtask

  initial begin
    reset     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_full();
    test_short();
    test_long();
    test_simul_wrap();
    test_abort(0);
    test_abort(1);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
